// File: rtl/decode_imm_stage.sv
// Registered decode stage between fetch and execute: opcode classification, immediate generation, one-cycle latency.
// Valid/ready on both sides with flush; `DECODE_SKID_BUF_EN adds a second FIFO entry so in_ready comes from a register.
package datatypes_pkg;
  typedef enum logic [2:0] {
    INSTR_R = 3'd0,
    INSTR_I = 3'd1,
    INSTR_S = 3'd2,
    INSTR_B = 3'd3,
    INSTR_U = 3'd4,
    INSTR_J = 3'd5
  } instr_type_t;
endpackage

module imm_gen_32
  import datatypes_pkg::*;
(
  input  logic [31:7]  ir,
  input  instr_type_t  instr_type,
  output logic [31:0]  imm
);
  always_comb begin
    imm = '0;
    case (instr_type)
      INSTR_I: imm = {{20{ir[31]}}, ir[31:20]};
      INSTR_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      INSTR_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      INSTR_U: imm = {ir[31:12], 12'b0};
      INSTR_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

module decode_imm_stage
  import datatypes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_type,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
    instr_type_t     typ;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

`ifdef DECODE_SKID_BUF_EN
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
`else
  typedef enum logic [0:0] {S_EMPTY, S_FULL} state_t;
`endif

  state_t          state, state_nxt;
  entry_t          main_q, in_entry;
  instr_type_t     dec_type;
  logic            dec_known, dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic            push, pop, load_main_in;

  // Decode happens on the input side so execute only ever sees registered values.
  always_comb begin
    dec_type  = INSTR_R;
    dec_known = 1'b1;
    case (in_ir[6:0])
      7'b0110111, 7'b0010111: dec_type = INSTR_U;
      7'b1101111:             dec_type = INSTR_J;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b0001111, 7'b1110011: dec_type = INSTR_I;
      7'b0100011:             dec_type = INSTR_S;
      7'b1100011:             dec_type = INSTR_B;
      7'b0110011:             dec_type = INSTR_R;
      default:                dec_known = 1'b0;
    endcase
  end

  assign dec_illegal = !dec_known || (in_ir[1:0] != 2'b11);

  imm_gen_32 u_imm_gen (
    .ir         (in_ir[31:7]),
    .instr_type (dec_type),
    .imm        (dec_imm)
  );

  assign in_entry = '{ir: in_ir, pc: in_pc, typ: dec_type, imm: dec_imm, illegal: dec_illegal};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

`ifdef DECODE_SKID_BUF_EN
  entry_t skid_q;
  logic   in_ready_q, load_skid, load_main_skid;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (push) state_nxt = S_ONE;
        S_ONE: begin
          if (push && !pop)      state_nxt = S_TWO;
          else if (!push && pop) state_nxt = S_EMPTY;
        end
        S_TWO:   if (pop) state_nxt = S_ONE;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid      = (state != S_EMPTY);
    in_ready       = in_ready_q && !flush;
    push           = in_valid && in_ready;
    pop            = out_valid && out_ready;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
    if (!flush) begin
      case (state)
        S_EMPTY: load_main_in = push;
        S_ONE: begin
          load_main_in = push && pop;
          load_skid    = push && !pop;
        end
        S_TWO:   load_main_skid = pop;
        default: ;
      endcase
    end
  end

  // in_ready is registered so fetch never sees a combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b1;
    else     in_ready_q <= (state_nxt != S_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            main_q <= '0;
    else if (load_main_in)   main_q <= in_entry;
    else if (load_main_skid) main_q <= skid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            skid_q <= '0;
    else if (load_skid) skid_q <= in_entry;
  end
`else
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (push) state_nxt = S_FULL;
        S_FULL:  if (pop && !push) state_nxt = S_EMPTY;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid    = (state == S_FULL);
    in_ready     = !flush && (!out_valid || out_ready);
    push         = in_valid && in_ready;
    pop          = out_valid && out_ready;
    load_main_in = push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               main_q <= '0;
    else if (load_main_in) main_q <= in_entry;
  end
`endif

  assign out_ir      = main_q.ir;
  assign out_pc      = main_q.pc;
  assign out_type    = main_q.typ;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: directed scenarios plus randomized traffic against a queue-based reference.
module tb_decode_imm_stage;
  import datatypes_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_ir, in_pc, out_ir, out_pc, out_imm;
  logic [2:0]  out_type;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_imm_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .out_type(out_type), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  typedef struct packed { logic [31:0] ir; logic [31:0] pc; } txn_t;
  txn_t q[$];

  // Snapshot taken at the falling edge, plus what the model expected at that moment.
  logic        s_valid, s_ready, s_illegal;
  logic [31:0] s_ir, s_pc, s_imm;
  logic [2:0]  s_type;
  logic        e_valid, e_ready;
  txn_t        e_head;

  function automatic logic [2:0] ref_type(input logic [31:0] ir);
    case (ir[6:0])
      7'h37, 7'h17:                      return INSTR_U;
      7'h6F:                             return INSTR_J;
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return INSTR_I;
      7'h23:                             return INSTR_S;
      7'h63:                             return INSTR_B;
      default:                           return INSTR_R;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ir);
    logic known;
    case (ir[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33: known = 1'b1;
      default: known = 1'b0;
    endcase
    return !known || (ir[1:0] != 2'b11);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ir);
    int v;
    v = 0;
    case (ref_type(ir))
      INSTR_I: begin
        v = int'(ir >> 20);
        if (ir[31]) v = v - 4096;
      end
      INSTR_S: begin
        v = int'((ir >> 25) * 32 + ((ir >> 7) & 32'd31));
        if (ir[31]) v = v - 4096;
      end
      INSTR_B: begin
        v = int'(((ir >> 8) & 32'd15) * 2 + ((ir >> 25) & 32'd63) * 32 + ((ir >> 7) & 32'd1) * 2048);
        if (ir[31]) v = v - 4096;
      end
      INSTR_U: v = int'(ir & 32'hFFFFF000);
      INSTR_J: begin
        v = int'(((ir >> 21) & 32'd1023) * 2 + ((ir >> 20) & 32'd1) * 2048 + ((ir >> 12) & 32'd255) * 4096);
        if (ir[31]) v = v - (1 << 20);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  // Drive one cycle of inputs, snapshot at negedge, advance the reference queue; returns at posedge+1.
  task automatic step(input logic iv, input logic [31:0] ir, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    txn_t t;
    logic took_in;
    in_valid = iv; in_ir = ir; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    s_valid = out_valid; s_ready = in_ready; s_ir = out_ir; s_pc = out_pc;
    s_type = out_type; s_imm = out_imm; s_illegal = out_illegal;
    e_valid = (q.size() > 0);
    if (e_valid) e_head = q[0];
`ifdef DECODE_SKID_BUF_EN
    e_ready = !fl && (q.size() < 2);
`else
    e_ready = !fl && (q.size() == 0 || ordy);
`endif
    took_in = iv && e_ready;
    if (e_valid && ordy) void'(q.pop_front());
    if (fl) q.delete();
    if (took_in) begin
      t.ir = ir; t.pc = pc;
      q.push_back(t);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h want=0", out_ir); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    total++; if (out_type !== INSTR_R) begin bad++; $display("FAIL reset_type got=%0d want=%0d", out_type, INSTR_R); end
    total++; if (out_imm !== 32'h0) begin bad++; $display("FAIL reset_imm got=%h want=0", out_imm); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_first();
    step(1'b1, 32'hFFF00093, 32'h0000_0100, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", out_valid); end
    total++; if (out_type !== INSTR_I) begin bad++; $display("FAIL first_type got=%0d want=%0d", out_type, INSTR_I); end
    total++; if (out_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL first_imm got=%h want=ffffffff", out_imm); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL first_illegal got=%b want=0", out_illegal); end
    total++; if (out_pc !== 32'h100) begin bad++; $display("FAIL first_pc got=%h want=100", out_pc); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] irs  [4] = '{32'h123452B7, 32'hFFDFF06F, 32'h00000463, 32'h00112223};
    logic [2:0]  tys  [4] = '{INSTR_U, INSTR_J, INSTR_B, INSTR_S};
    logic [31:0] imms [4] = '{32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h00000004};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, irs[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, s_ready); end
      total++; if (out_valid !== 1'b1 || out_ir !== irs[i]) begin bad++; $display("FAIL b2b_ir[%0d] got=%b/%h want=1/%h", i, out_valid, out_ir, irs[i]); end
      total++; if (out_pc !== 32'h200 + 32'(4 * i)) begin bad++; $display("FAIL b2b_pc[%0d] got=%h want=%h", i, out_pc, 32'h200 + 32'(4 * i)); end
      total++; if (out_type !== tys[i]) begin bad++; $display("FAIL b2b_type[%0d] got=%0d want=%0d", i, out_type, tys[i]); end
      total++; if (out_imm !== imms[i]) begin bad++; $display("FAIL b2b_imm[%0d] got=%h want=%h", i, out_imm, imms[i]); end
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] irs [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    logic [31:0] got[$];
    int acc = 0;
    int want_acc;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, irs[i], 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      if (s_ready) acc++;
`ifndef DECODE_SKID_BUF_EN
      if (i > 0) begin
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full[%0d] got=%b want=0", i, s_ready); end
      end
`endif
      total++; if (out_valid !== 1'b1 || out_ir !== irs[0]) begin bad++; $display("FAIL bp_stable[%0d] got=%b/%h want=1/%h", i, out_valid, out_ir, irs[0]); end
    end
`ifdef DECODE_SKID_BUF_EN
    want_acc = 2;
`else
    want_acc = 1;
`endif
    total++; if (acc != want_acc) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc, want_acc); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (s_valid) got.push_back(s_ir);
    end
    total++; if (got.size() != want_acc) begin bad++; $display("FAIL bp_drain_count got=%0d want=%0d", got.size(), want_acc); end
    for (int i = 0; i < got.size() && i < want_acc; i++) begin
      total++; if (got[i] !== irs[i]) begin bad++; $display("FAIL bp_drain_order[%0d] got=%h want=%h", i, got[i], irs[i]); end
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0);
    total++; if (out_illegal !== 1'b1) begin bad++; $display("FAIL illegal_7f got=%b want=1", out_illegal); end
    total++; if (out_type !== INSTR_R) begin bad++; $display("FAIL illegal_7f_type got=%0d want=%0d", out_type, INSTR_R); end
    step(1'b1, 32'h00000000, 32'h404, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin bad++; $display("FAIL illegal_zero got=%b/%b want=1/1", out_valid, out_illegal); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 32'h00500293, 32'h500, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h504, 1'b0, 1'b1);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", s_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL flush_not_captured got=%b want=0", s_valid); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h00700393, 32'h600, 1'b1, 1'b0);
    in_valid = 1'b1; in_ir = 32'h00800413; in_pc = 32'h604;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    total++; if (out_ir !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0) begin bad++; $display("FAIL arst_data got=%h/%h/%h want=0/0/0", out_ir, out_pc, out_imm); end
    total++; if (out_type !== INSTR_R || out_illegal !== 1'b0) begin bad++; $display("FAIL arst_type got=%0d/%b want=0/0", out_type, out_illegal); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b want=1", in_ready); end
    step(1'b1, 32'h00A00513, 32'h700, 1'b1, 1'b0);
    total++; if (out_valid !== 1'b1 || out_type !== INSTR_I || out_imm !== 32'hA) begin bad++; $display("FAIL arst_after got=%b/%0d/%h want=1/1/a", out_valid, out_type, out_imm); end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]  ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33, 7'h7F};
    logic [31:0] r, ir;
    for (int c = 0; c < 1500; c++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) ir = $urandom();
      else ir = {r[31:7], ops[$urandom_range(0, 11)]};
      step(($urandom_range(0, 3) != 0), ir, $urandom(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      total++; if (s_valid !== e_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, s_valid, e_valid); end
      total++; if (s_ready !== e_ready) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b want=%b", c, s_ready, e_ready); end
      if (e_valid) begin
        total++; if (s_ir !== e_head.ir || s_pc !== e_head.pc) begin bad++; $display("FAIL rnd_irpc[%0d] got=%h/%h want=%h/%h", c, s_ir, s_pc, e_head.ir, e_head.pc); end
        total++; if (s_type !== ref_type(e_head.ir)) begin bad++; $display("FAIL rnd_type[%0d] got=%0d want=%0d", c, s_type, ref_type(e_head.ir)); end
        total++; if (s_imm !== ref_imm(e_head.ir)) begin bad++; $display("FAIL rnd_imm[%0d] ir=%h got=%h want=%h", c, e_head.ir, s_imm, ref_imm(e_head.ir)); end
        total++; if (s_illegal !== ref_illegal(e_head.ir)) begin bad++; $display("FAIL rnd_illegal[%0d] got=%b want=%b", c, s_illegal, ref_illegal(e_head.ir)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; out_ready = 1'b0;
    test_reset();
    test_first();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
